// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: feeds an external 4-bit adder one slice per
// clock and assembles the wide sum. Also provides the ckt4 ripple slice it drives.

module ckt4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin_in,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout_out
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [IW-1:0]        idx;
  logic                 carry;
  logic [4*NIBBLES-1:0] a_q, b_q;
  logic                 last;

  assign last = (idx == IW'(NIBBLES - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        add_a   = a_q[4*idx +: 4];
        add_b   = b_q[4*idx +: 4];
        add_cin = carry;
        if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands are captured once at acceptance so input changes mid-run are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum      <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q      <= op_a;
          b_q      <= op_b;
          carry    <= cin_in;
          idx      <= '0;
          sum      <= '0;
          cout_out <= 1'b0;
        end
        RUN: begin
          sum[4*idx +: 4] <= add_s;
          carry           <= add_cout;
          if (last) cout_out <= add_cout;
          else      idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: sequencer wired to a ckt4 slice; results checked on each done pulse.

module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, start, cin_in;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout;
  logic         busy, done, cout_out;
  logic [W-1:0] sum;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout_out(cout_out)
  );

  ckt4 u_add (.a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  logic [W:0] exp_q[$];
  int         acc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every done pulse must match the oldest outstanding accepted operation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      chk("busy_done_excl", {31'b0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        int         a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("done_latency", cyc - a, N);
        chk("sum", {16'b0, sum}, {16'b0, e[W-1:0]});
        chk("cout_out", {31'b0, cout_out}, {31'b0, e[W]});
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input bit score);
    op_a = a; op_b = b; cin_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", {31'b0, busy}, 32'd1);
    chk("accept_sum_clr", {15'b0, cout_out, sum}, 32'd0);
    chk("add_a_nib0", {28'b0, add_a}, {28'b0, a[3:0]});
    if (score) begin
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci});
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    tick();
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] m;
    m = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    do_op(a, b, ci, 1'b1);
    wait_done();
    tick();
    chk("sum_stable", {15'b0, cout_out, sum}, {15'b0, m});
    chk("idle_add_a", {27'b0, add_cin, add_a}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {15'b0, cout_out, sum}, 32'd0);
    chk("rst_add", {23'b0, add_cin, add_a, add_b}, 32'd0);
    rst = 1'b0;
    tick();

    run(16'h0006, 16'h0003, 1'b0);
    run(16'h000C, 16'h0005, 1'b1);
    run(16'hFFFF, 16'h0001, 1'b0);
    run(16'h8000, 16'h8000, 1'b1);

    // start with different operands mid-run must be ignored
    do_op(16'h1234, 16'h1111, 1'b0, 1'b1);
    tick();
    op_a = 16'hFFFF; op_b = 16'hFFFF; cin_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    run(16'h0F0F, 16'h0101, 1'b0);

    for (int i = 0; i < 4; i++)
      run(W'($urandom), W'($urandom), 1'($urandom));

    // reset in the middle of a run: outputs clear, no done follows
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_sum", {15'b0, cout_out, sum}, 32'd0);
    repeat (8) tick();
    chk("post_rst_idle", {30'b0, busy, done}, 32'd0);

    run(16'hFFFF, 16'hFFFF, 1'b1);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
